// File: rtl/alu4_pkg.sv
// Shared definitions for the 4-bit algebraic ALU and its result checker:
// ctrl encodings, data width, result record and checker state encoding.
package alu4_pkg;

    localparam int DATA_W = 4;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    // Packs as {f, zero, ovf}, the layout reported in the first-fail record.
    typedef struct packed {
        logic [DATA_W-1:0] f;
        logic              zero;
        logic              ovf;
    } result_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu4_golden.sv
// Combinational golden model of the 4-bit ALU: recomputes f/zero/ovf for a
// vector and flags ctrl codes the ALU does not implement.
module alu4_golden
    import alu4_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        ctrl,
    output logic [DATA_W-1:0] f,
    output logic              zero,
    output logic              ovf,
    output logic              illegal
);

    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;
    logic              w_add_ovf;
    logic              w_sub_ovf;

    assign w_sum     = a + b;
    assign w_diff    = a - b;
    assign w_add_ovf = (a[DATA_W-1] == b[DATA_W-1]) && (w_sum[DATA_W-1]  != a[DATA_W-1]);
    assign w_sub_ovf = (a[DATA_W-1] != b[DATA_W-1]) && (w_diff[DATA_W-1] != a[DATA_W-1]);

    always_comb begin
        f       = '0;
        ovf     = 1'b0;
        illegal = 1'b0;
        case (ctrl)
            OP_AND: f = a & b;
            OP_OR:  f = a | b;
            OP_ADD: begin
                f   = w_sum;
                ovf = w_add_ovf;
            end
            OP_SUB: begin
                f   = w_diff;
                ovf = w_sub_ovf;
            end
            // Signed less-than: true sign of a-b is the raw sign corrected by overflow.
            OP_SLT: begin
                f   = {{(DATA_W-1){1'b0}}, w_diff[DATA_W-1] ^ w_sub_ovf};
                ovf = w_sub_ovf;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign zero = (f == '0);

endmodule

// File: rtl/alu4_result_checker.sv
// On-chip result checker for alu4: two-stage pipeline (golden capture, then
// compare/count) bounded by an IDLE/RUN/DONE session of N_VECTORS vectors.
module alu4_result_checker
    import alu4_pkg::*;
#(
    parameter int N_VECTORS = 1280,
    parameter int CNT_W     = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic [2:0]       in_ctrl,
    input  logic [3:0]       in_f,
    input  logic             in_zero,
    input  logic             in_ovf,
    output logic             busy,
    output logic             done,
    output logic             err_pulse,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] illegal_cnt,
    output logic             ff_valid,
    output logic [10:0]      ff_vec,
    output logic [5:0]       ff_exp,
    output logic [5:0]       ff_got
);

    localparam int SUM_W = CNT_W + 1;

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_s1_valid;
    logic              r_s1_illegal;
    logic [10:0]       r_s1_vec;
    result_t           r_s1_exp;
    result_t           r_s1_got;

    logic              r_err;
    logic [CNT_W-1:0]  r_pass;
    logic [CNT_W-1:0]  r_fail;
    logic [CNT_W-1:0]  r_illegal;
    logic              r_ff_valid;
    logic [10:0]       r_ff_vec;
    result_t           r_ff_exp;
    result_t           r_ff_got;

    logic [3:0]        w_gold_f;
    logic              w_gold_zero;
    logic              w_gold_ovf;
    logic              w_gold_illegal;
    logic              w_sum_hit;
    logic              w_accept;
    logic              w_s2_en;
    logic              w_match;
    logic              w_mismatch;
    logic              w_illegal_hit;

    alu4_golden u_golden (
        .a       (in_a),
        .b       (in_b),
        .ctrl    (in_ctrl),
        .f       (w_gold_f),
        .zero    (w_gold_zero),
        .ovf     (w_gold_ovf),
        .illegal (w_gold_illegal)
    );

    // Once the session total is reached, nothing more is accepted or counted;
    // whatever still sits in S1 is dropped on the way into DONE.
    assign w_sum_hit     = ({1'b0, r_pass} + {1'b0, r_fail}) == SUM_W'(N_VECTORS);
    assign w_accept      = (r_state == RUN) && !start && in_valid && !w_sum_hit;
    assign w_s2_en       = r_s1_valid && (r_state == RUN) && !w_sum_hit;
    assign w_illegal_hit = w_s2_en && r_s1_illegal;
    assign w_match       = w_s2_en && !r_s1_illegal && (r_s1_exp == r_s1_got);
    assign w_mismatch    = w_s2_en && !r_s1_illegal && (r_s1_exp != r_s1_got);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (start) w_state_nxt = RUN;
                     else if (w_sum_hit) w_state_nxt = DONE;
            DONE:    if (start) w_state_nxt = RUN;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst || start) begin
            r_s1_valid   <= 1'b0;
            r_s1_illegal <= 1'b0;
            r_s1_vec     <= '0;
            r_s1_exp     <= '0;
            r_s1_got     <= '0;
            r_err        <= 1'b0;
            r_pass       <= '0;
            r_fail       <= '0;
            r_illegal    <= '0;
            r_ff_valid   <= 1'b0;
            r_ff_vec     <= '0;
            r_ff_exp     <= '0;
            r_ff_got     <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_illegal <= w_gold_illegal;
                r_s1_vec     <= {in_a, in_b, in_ctrl};
                r_s1_exp     <= {w_gold_f, w_gold_zero, w_gold_ovf};
                r_s1_got     <= {in_f, in_zero, in_ovf};
            end

            r_err <= w_mismatch;
            if (w_match)       r_pass    <= f_sat_inc(r_pass);
            if (w_mismatch)    r_fail    <= f_sat_inc(r_fail);
            if (w_illegal_hit) r_illegal <= f_sat_inc(r_illegal);

            if (w_mismatch && !r_ff_valid) begin
                r_ff_valid <= 1'b1;
                r_ff_vec   <= r_s1_vec;
                r_ff_exp   <= r_s1_exp;
                r_ff_got   <= r_s1_got;
            end
        end
    end

    assign busy        = (r_state == RUN);
    assign done        = (r_state == DONE);
    assign err_pulse   = r_err;
    assign pass_cnt    = r_pass;
    assign fail_cnt    = r_fail;
    assign illegal_cnt = r_illegal;
    assign ff_valid    = r_ff_valid;
    assign ff_vec      = r_ff_vec;
    assign ff_exp      = r_ff_exp;
    assign ff_got      = r_ff_got;

endmodule

// File: tb/tb_alu4_result_checker.sv
// Bench for alu4_result_checker: integer-arithmetic reference of the ALU and
// session rules, per-cycle compare against the DUT, plus directed literals.
module tb_alu4_result_checker;

    localparam int N1 = 1280;
    localparam int W1 = 12;
    localparam logic [2:0] C_AND = 3'b000;
    localparam logic [2:0] C_OR  = 3'b001;
    localparam logic [2:0] C_ADD = 3'b010;
    localparam logic [2:0] C_SUB = 3'b110;
    localparam logic [2:0] C_SLT = 3'b111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, in_valid, in_zero, in_ovf;
    logic [3:0] in_a, in_b, in_f;
    logic [2:0] in_ctrl;
    logic       rst2, start2;

    logic          busy, done, err_pulse, ff_valid;
    logic [W1-1:0] pass_cnt, fail_cnt, illegal_cnt;
    logic [10:0]   ff_vec;
    logic [5:0]    ff_exp, ff_got;

    logic        busy2, done2, err2, ffv2;
    logic [1:0]  pass2, fail2, ill2;
    logic [10:0] ffvec2;
    logic [5:0]  ffexp2, ffgot2;

    alu4_result_checker #(.N_VECTORS(N1), .CNT_W(W1)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_a(in_a), .in_b(in_b), .in_ctrl(in_ctrl), .in_f(in_f),
        .in_zero(in_zero), .in_ovf(in_ovf),
        .busy(busy), .done(done), .err_pulse(err_pulse),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .illegal_cnt(illegal_cnt),
        .ff_valid(ff_valid), .ff_vec(ff_vec), .ff_exp(ff_exp), .ff_got(ff_got)
    );

    alu4_result_checker #(.N_VECTORS(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst2), .start(start2), .in_valid(in_valid),
        .in_a(in_a), .in_b(in_b), .in_ctrl(in_ctrl), .in_f(in_f),
        .in_zero(in_zero), .in_ovf(in_ovf),
        .busy(busy2), .done(done2), .err_pulse(err2),
        .pass_cnt(pass2), .fail_cnt(fail2), .illegal_cnt(ill2),
        .ff_valid(ffv2), .ff_vec(ffvec2), .ff_exp(ffexp2), .ff_got(ffgot2)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            if (fails <= 40) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // {illegal, f, zero, ovf} from plain signed integer arithmetic.
    function automatic logic [6:0] spec_result(input logic [3:0] a, input logic [3:0] b,
                                               input logic [2:0] ctrl);
        int sa, sb, r, f;
        bit ov, ill;
        sa  = (a > 7) ? int'(a) - 16 : int'(a);
        sb  = (b > 7) ? int'(b) - 16 : int'(b);
        f   = 0;
        ov  = 1'b0;
        ill = 1'b0;
        case (ctrl)
            C_AND: f = int'(a & b);
            C_OR:  f = int'(a | b);
            C_ADD: begin r = sa + sb; f = (r + 16) % 16; ov = (r > 7) || (r < -8); end
            C_SUB: begin r = sa - sb; f = (r + 16) % 16; ov = (r > 7) || (r < -8); end
            C_SLT: begin r = sa - sb; f = (sa < sb) ? 1 : 0; ov = (r > 7) || (r < -8); end
            default: ill = 1'b1;
        endcase
        return {ill, 4'(f), (f == 0), ov};
    endfunction

    function automatic int sat(input int v);
        int mx;
        mx = (1 << W1) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Reference session model, advanced once per rising edge.
    typedef struct {
        int          due;
        logic [10:0] vec;
        logic [5:0]  got;
    } pend_t;

    pend_t       q[$];
    int          cyc = 0;
    bit          m_run = 0, m_done = 0, m_err = 0, m_ffv = 0;
    int          m_pass = 0, m_fail = 0, m_ill = 0;
    logic [10:0] m_ffvec = '0;
    logic [5:0]  m_ffexp = '0, m_ffgot = '0;

    always @(posedge clk) begin
        bit         full;
        pend_t      p;
        pend_t      n;
        logic [6:0] r;
        if (rst || start) begin
            q.delete();
            m_pass = 0; m_fail = 0; m_ill = 0; m_err = 0; m_ffv = 0;
            m_run  = !rst;
            m_done = 0;
        end else begin
            full  = m_run && (sat(m_pass) + sat(m_fail) == N1);
            m_err = 0;
            while (q.size() > 0 && q[0].due <= cyc) begin
                p = q.pop_front();
                if (m_run && !full) begin
                    r = spec_result(p.vec[10:7], p.vec[6:3], p.vec[2:0]);
                    if (r[6]) m_ill++;
                    else if (r[5:0] == p.got) m_pass++;
                    else begin
                        m_fail++;
                        m_err = 1;
                        if (!m_ffv) begin
                            m_ffv = 1; m_ffvec = p.vec; m_ffexp = r[5:0]; m_ffgot = p.got;
                        end
                    end
                end
            end
            if (m_run && !full && in_valid) begin
                n.due = cyc + 1;
                n.vec = {in_a, in_b, in_ctrl};
                n.got = {in_f, in_zero, in_ovf};
                q.push_back(n);
            end
            if (full) begin
                m_run = 0; m_done = 1; q.delete();
            end
        end
        cyc = cyc + 1;
    end

    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy",        busy,        m_run);
            check("done",        done,        m_done);
            check("err_pulse",   err_pulse,   m_err);
            check("pass_cnt",    pass_cnt,    sat(m_pass));
            check("fail_cnt",    fail_cnt,    sat(m_fail));
            check("illegal_cnt", illegal_cnt, sat(m_ill));
            check("ff_valid",    ff_valid,    m_ffv);
            if (m_ffv) begin
                check("ff_vec", ff_vec, m_ffvec);
                check("ff_exp", ff_exp, m_ffexp);
                check("ff_got", ff_got, m_ffgot);
            end
        end
    end

    bit track = 0;
    int t_done = -1;
    always @(negedge clk) if (track && done === 1'b1 && t_done < 0) t_done = cyc;

    task automatic put(input logic [3:0] a, input logic [3:0] b, input logic [2:0] c,
                       input logic [3:0] f, input logic z, input logic o);
        in_a = a; in_b = b; in_ctrl = c; in_f = f; in_zero = z; in_ovf = o;
        in_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic drive_vec(input logic [3:0] a, input logic [3:0] b, input logic [2:0] c,
                             input logic [3:0] f, input logic z, input logic o);
        put(a, b, c, f, z, o);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    logic [2:0] ops [5] = '{C_AND, C_OR, C_ADD, C_SUB, C_SLT};

    initial begin
        int c0;
        logic [6:0] r;
        bit first;
        rst = 1; start = 0; in_valid = 0; rst2 = 1; start2 = 0;
        in_a = 0; in_b = 0; in_ctrl = 0; in_f = 0; in_zero = 0; in_ovf = 0;
        c0 = 0;

        check("pin_add",  spec_result(4'd7, 4'd1, C_ADD), 7'b0_1000_0_1);
        check("pin_slt",  spec_result(4'b1000, 4'd1, C_SLT), 7'b0_0001_0_1);
        check("pin_sub",  spec_result(4'd0, 4'd0, C_SUB), 7'b0_0000_1_0);
        check("pin_ill",  spec_result(4'd3, 4'd3, 3'b011) >> 6, 1);

        repeat (3) @(negedge clk);
        cmp_en = 1;
        check("rst_ff_vec", ff_vec, 0);
        check("rst_ff_exp", ff_exp, 0);
        check("rst_ff_got", ff_got, 0);
        rst = 0;
        @(negedge clk);

        // Exhaustive sweep with a correct ALU, then two bad vectors past the end.
        pulse_start();
        track = 1;
        first = 1;
        for (int oi = 0; oi < 5; oi++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++) begin
                    r = spec_result(4'(a), 4'(b), ops[oi]);
                    if (first) begin c0 = cyc; first = 0; end
                    put(4'(a), 4'(b), ops[oi], r[5:2], r[1], r[0]);
                end
        put(4'd0, 4'd0, C_AND, 4'hF, 1'b0, 1'b0);
        put(4'd0, 4'd0, C_AND, 4'hF, 1'b0, 1'b0);
        in_valid = 0;
        for (int i = 0; i < 20 && t_done < 0; i++) @(negedge clk);
        check("done_latency", t_done - c0, 1282);
        check("sweep_pass", pass_cnt, 1280);
        check("sweep_fail", fail_cnt, 0);
        check("sweep_ffv",  ff_valid, 0);
        check("sweep_done", done, 1);

        // Directed single vectors.
        pulse_start();
        drive_vec(4'd7, 4'd1, C_ADD, 4'd8, 1'b0, 1'b1); @(negedge clk);
        check("add_pass", pass_cnt, 1);
        drive_vec(4'd7, 4'd1, C_ADD, 4'd8, 1'b0, 1'b0); @(negedge clk);
        check("add_err_pulse", err_pulse, 1);
        check("add_ff_exp", ff_exp, 6'b1000_0_1);
        check("add_ff_got", ff_got, 6'b1000_0_0);
        check("add_ff_vec", ff_vec, 11'b0111_0001_010);
        drive_vec(4'b1000, 4'd1, C_SLT, 4'd1, 1'b0, 1'b1); @(negedge clk);
        check("slt_pass", pass_cnt, 2);
        drive_vec(4'b1000, 4'd1, C_SLT, 4'd0, 1'b0, 1'b1); @(negedge clk);
        check("slt_fail", fail_cnt, 2);
        drive_vec(4'd0, 4'd0, C_SUB, 4'd0, 1'b1, 1'b0); @(negedge clk);
        check("sub_pass", pass_cnt, 3);
        drive_vec(4'd5, 4'd3, 3'b011, 4'd0, 1'b0, 1'b0); @(negedge clk);
        check("ill_cnt", illegal_cnt, 1);
        check("ill_pass_same", pass_cnt, 3);

        // Fresh session: illegal then two back-to-back fails.
        pulse_start();
        put(4'd5, 4'd3, 3'b011, 4'd0, 1'b0, 1'b0);
        put(4'd1, 4'd1, C_AND, 4'd0, 1'b1, 1'b0);
        put(4'd2, 4'd2, C_OR,  4'd0, 1'b1, 1'b0);
        in_valid = 0; @(negedge clk);
        check("b_ill", illegal_cnt, 1);
        check("b_fail", fail_cnt, 2);
        check("b_ff_vec", ff_vec, 11'b0001_0001_000);

        // Restart with vectors in flight; the start cycle's vector is ignored.
        put(4'd3, 4'd4, C_ADD, 4'd7, 1'b0, 1'b0);
        put(4'd3, 4'd4, C_ADD, 4'd0, 1'b0, 1'b0);
        start = 1;
        put(4'd3, 4'd4, C_ADD, 4'd0, 1'b0, 1'b0);
        start = 0; in_valid = 0;
        check("rs_pass0", pass_cnt, 0);
        check("rs_fail0", fail_cnt, 0);
        repeat (3) @(negedge clk);
        check("rs_pass_later", pass_cnt, 0);
        check("rs_fail_later", fail_cnt, 0);
        check("rs_busy", busy, 1);

        // Reset during RUN with three fails recorded.
        repeat (3) put(4'd1, 4'd2, C_AND, 4'hF, 1'b0, 1'b0);
        in_valid = 0; @(negedge clk);
        check("pre_rst_fail", fail_cnt, 3);
        rst = 1; @(negedge clk);
        check("r_busy", busy, 0);
        check("r_fail", fail_cnt, 0);
        check("r_ffv",  ff_valid, 0);
        check("r_ffvec", ff_vec, 0);
        rst = 0; @(negedge clk);
        drive_vec(4'd1, 4'd1, C_AND, 4'd1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("idle_pass", pass_cnt, 0);
        check("idle_busy", busy, 0);

        // Narrow build: counters saturate, done never asserts.
        rst2 = 0; @(negedge clk);
        start2 = 1; @(negedge clk); start2 = 0;
        repeat (5) put(4'd1, 4'd1, C_AND, 4'd1, 1'b0, 1'b0);
        in_valid = 0;
        repeat (3) @(negedge clk);
        check("sat_pass", pass2, 3);
        check("sat_fail", fail2, 0);
        check("sat_done", done2, 0);
        check("sat_busy", busy2, 1);

        cmp_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
